// File: rtl/rf_writeback.sv
// Register-file writeback: round-robin arbitration of ALU/load results into a FIFO
// feeding the single write port. Optional forwarding built when RF_WB_BYPASS_EN is defined.
module rf_writeback #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [AW-1:0]            a_rd,
  input  logic [DW-1:0]            a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [AW-1:0]            b_rd,
  input  logic [DW-1:0]            b_data,
  input  logic                     drain_en,
  output logic                     wE,
  output logic [AW-1:0]            rW,
  output logic [DW-1:0]            busW,
  input  logic [AW-1:0]            chk_ra,
  input  logic [AW-1:0]            chk_rb,
  output logic                     pend_a,
  output logic                     pend_b,
  output logic [DW-1:0]            fwd_a,
  output logic [DW-1:0]            fwd_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_rd   [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          last_b;

  logic          space;
  logic          a_fire;
  logic          b_fire;
  logic          push;
  logic          pop;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;

  // Arbitration: the port not granted last wins a contention; ready is gated by valid
  // so the two readies can never be high together.
  assign space   = (cnt < CW'(DEPTH));
  assign a_ready = a_valid && space && (!b_valid || last_b);
  assign b_ready = b_valid && space && (!a_valid || !last_b);
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;
  assign in_rd   = a_fire ? a_rd   : b_rd;
  assign in_data = a_fire ? a_data : b_data;
  assign push    = (a_fire && (a_rd != '0)) || (b_fire && (b_rd != '0));
  assign pop     = (cnt != '0) && drain_en;
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_b <= 1'b1;
      wE     <= 1'b0;
      rW     <= '0;
      busW   <= '0;
    end else begin
      if (a_fire) begin
        last_b <= 1'b0;
      end else if (b_fire) begin
        last_b <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      // Output stage: head moves to the write port, otherwise rW/busW hold.
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        wE     <= 1'b1;
        rW     <= q_rd[rd_ptr];
        busW   <= q_data[rd_ptr];
      end else begin
        wE     <= 1'b0;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; liveness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= in_rd;
      q_data[wr_ptr] <= in_data;
    end
  end

  logic [PW-1:0] pidx;

  always_comb begin
    pend_a = wE && (rW == chk_ra);
    pend_b = wE && (rW == chk_rb);
    pidx   = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      pidx = rd_ptr + PW'(i);
      if (CW'(i) < cnt) begin
        if (q_rd[pidx] == chk_ra) pend_a = 1'b1;
        if (q_rd[pidx] == chk_rb) pend_b = 1'b1;
      end
    end
    if (chk_ra == '0) pend_a = 1'b0;
    if (chk_rb == '0) pend_b = 1'b0;
  end

`ifdef RF_WB_BYPASS_EN
  logic [PW-1:0] fidx;

  // Walk oldest to newest so the youngest match overrides; output stage is oldest.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    fidx  = rd_ptr;
    if (wE && (rW == chk_ra)) fwd_a = busW;
    if (wE && (rW == chk_rb)) fwd_b = busW;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = rd_ptr + PW'(i);
      if (CW'(i) < cnt) begin
        if (q_rd[fidx] == chk_ra) fwd_a = q_data[fidx];
        if (q_rd[fidx] == chk_rb) fwd_b = q_data[fidx];
      end
    end
    if (chk_ra == '0) fwd_a = '0;
    if (chk_rb == '0) fwd_b = '0;
  end
`else
  assign fwd_a = '0;
  assign fwd_b = '0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: queue-based reference model, directed scenarios
// followed by randomized producer traffic.
module tb_rf_writeback;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, drain_en = 1'b0;
  logic [4:0]  a_rd = '0, b_rd = '0, chk_ra = '0, chk_rb = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, wE, pend_a, pend_b;
  logic [4:0]  rW;
  logic [31:0] busW, fwd_a, fwd_b;
  logic [2:0]  count;

  rf_writeback #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .drain_en(drain_en), .wE(wE), .rW(rW), .busW(busW),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .pend_a(pend_a), .pend_b(pend_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  item_t       m_fifo[$];
  item_t       exp_q[$];
  logic        m_last_b = 1'b1;
  logic        m_we = 1'b0;
  logic [4:0]  m_rw = '0;
  logic [31:0] m_bus = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_pend(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (m_we && m_rw == r) return 1'b1;
    foreach (m_fifo[i]) if (m_fifo[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r);
    if (r == 0) return 32'h0;
    for (int i = m_fifo.size() - 1; i >= 0; i--)
      if (m_fifo[i].rd == r) return m_fifo[i].data;
    if (m_we && m_rw == r) return m_bus;
    return 32'h0;
  endfunction

  function automatic void m_reset();
    m_fifo.delete();
    exp_q.delete();
    m_last_b = 1'b1;
    m_we = 1'b0;
    m_rw = '0;
    m_bus = '0;
  endfunction

  // Monitor: every cycle the write port is enabled, it must carry the next expected write.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (rst_n && wE) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", {27'h0, rW}, 32'hFFFF_FFFF);
        end else begin
          it = exp_q.pop_front();
          chk("write_rd", {27'h0, rW}, {27'h0, it.rd});
          chk("write_data", busW, it.data);
        end
      end
    end
  end

  // One cycle: apply inputs at negedge, check combinational outputs, advance the model.
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                     input logic de, input logic [4:0] ca, input logic [4:0] cb,
                     output logic fa, output logic fb);
    logic space;
    item_t it;
    @(negedge clk);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    drain_en = de; chk_ra = ca; chk_rb = cb;
    #1;
    space = (m_fifo.size() < DEPTH);
    fa = av && space && (!bv || m_last_b);
    fb = bv && space && (!av || !m_last_b);
    chk("a_ready", {31'h0, a_ready}, {31'h0, fa});
    chk("b_ready", {31'h0, b_ready}, {31'h0, fb});
    chk("count", {29'h0, count}, m_fifo.size());
    chk("pend_a", {31'h0, pend_a}, {31'h0, m_pend(ca)});
    chk("pend_b", {31'h0, pend_b}, {31'h0, m_pend(cb)});
`ifdef RF_WB_BYPASS_EN
    chk("fwd_a", fwd_a, m_fwd(ca));
    chk("fwd_b", fwd_b, m_fwd(cb));
`else
    chk("fwd_a", fwd_a, 32'h0);
    chk("fwd_b", fwd_b, 32'h0);
`endif
    if (m_fifo.size() > 0 && de) begin
      it = m_fifo.pop_front();
      exp_q.push_back(it);
      m_we = 1'b1; m_rw = it.rd; m_bus = it.data;
    end else begin
      m_we = 1'b0;
    end
    if (fa) begin
      m_last_b = 1'b0;
      if (ard != 0) m_fifo.push_back('{rd: ard, data: ad});
    end
    if (fb) begin
      m_last_b = 1'b1;
      if (brd != 0) m_fifo.push_back('{rd: brd, data: bd});
    end
  endtask

  task automatic idle(input int n);
    logic fa, fb;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, fa, fb);
  endtask

  initial begin
    logic fa, fb;
    logic [3:0] grants;
    int got;
    logic ah, bh;
    logic [4:0] ar, br;
    logic [31:0] ad, bd;

    // Reset state
    #12;
    chk("rst_wE", {31'h0, wE}, 32'h0);
    chk("rst_rW", {27'h0, rW}, 32'h0);
    chk("rst_busW", busW, 32'h0);
    chk("rst_count", {29'h0, count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // Single ALU write and its latency to the write port
    cyc(1, 3, 32'h1234_5678, 0, 0, 0, 1, 0, 0, fa, fb);
    chk("t1_accept", {31'h0, fa}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, fa, fb);
    @(posedge clk); #1;
    chk("t1_wE", {31'h0, wE}, 32'h1);
    chk("t1_rW", {27'h0, rW}, 32'd3);
    chk("t1_busW", busW, 32'h1234_5678);
    chk("t1_count", {29'h0, count}, 32'h0);
    idle(2);

    // Contention: alternating grants starting from whichever port the model expects
    grants = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 32'hA000 + i, 1, 2, 32'hB000 + i, 1, 1, 2, fa, fb);
      grants[i] = fb;
      chk("both_ready", {31'h0, a_ready & b_ready}, 32'h0);
    end
    chk("t2_alternate", {28'h0, grants}, {28'h0, m_last_b ? 4'b1010 : 4'b0101});
    idle(4);

    // Full FIFO with drain frozen, then release
    got = 0;
    while (got < 4) begin
      cyc(1, 5'd10 + got[4:0], 32'hC0 + got, 0, 0, 0, 0, 10, 13, fa, fb);
      if (fa) got++;
    end
    cyc(1, 14, 32'hC4, 0, 0, 0, 0, 14, 0, fa, fb);
    chk("t3_full_block", {31'h0, fa}, 32'h0);
    chk("t3_count", {29'h0, count}, 32'd4);
    fa = 0;
    for (int i = 0; i < 8 && !fa; i++) cyc(1, 14, 32'hC4, 0, 0, 0, 1, 14, 0, fa, fb);
    chk("t3_fifth_accepted", {31'h0, fa}, 32'h1);
    idle(6);

    // r0 discard
    cyc(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, fa, fb);
    chk("t4_r0_accept", {31'h0, fa}, 32'h1);
    idle(1);
    chk("t4_r0_count", {29'h0, count}, 32'h0);
    chk("t4_r0_noWE", {31'h0, wE}, 32'h0);
    idle(2);

    // Pending / forwarding on two queued writes to r7
    cyc(1, 7, 32'hA, 0, 0, 0, 0, 0, 0, fa, fb);
    cyc(1, 7, 32'hB, 0, 0, 0, 0, 0, 0, fa, fb);
    cyc(0, 0, 0, 0, 0, 0, 0, 7, 0, fa, fb);
    chk("t5_pend_a", {31'h0, pend_a}, 32'h1);
    chk("t5_pend_b", {31'h0, pend_b}, 32'h0);
`ifdef RF_WB_BYPASS_EN
    chk("t5_fwd_a", fwd_a, 32'hB);
`endif
    idle(4);

    // Asynchronous reset in the middle of activity
    for (int i = 0; i < 3; i++) cyc(1, 5'd20 + i[4:0], 32'hD0 + i, 0, 0, 0, 0, 0, 0, fa, fb);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, fa, fb);
    @(posedge clk); #1;
    chk("t6_pre_wE", {31'h0, wE}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_wE", {31'h0, wE}, 32'h0);
    chk("t6_rW", {27'h0, rW}, 32'h0);
    chk("t6_busW", busW, 32'h0);
    chk("t6_count", {29'h0, count}, 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 4, 32'h44, 1, 5, 32'h55, 1, 0, 0, fa, fb);
    chk("t6_a_wins", {31'h0, fa}, 32'h1);
    idle(4);

    // Randomized producers that hold their transaction until accepted
    ah = 0; bh = 0; ar = 0; br = 0; ad = 0; bd = 0;
    for (int n = 0; n < 600; n++) begin
      if (!ah && ($urandom_range(0, 2) != 0)) begin
        ah = 1; ar = 5'($urandom_range(0, 7)); ad = $urandom;
      end
      if (!bh && ($urandom_range(0, 2) != 0)) begin
        bh = 1; br = 5'($urandom_range(0, 7)); bd = $urandom;
      end
      cyc(ah, ar, ad, bh, br, bd, ($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), fa, fb);
      if (fa) ah = 0;
      if (fb) bh = 0;
    end
    idle(10);
    chk("final_model_empty", m_fifo.size(), 32'h0);
    chk("final_writes_seen", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
